fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch buffer between the instruction fetch stage and the IF/ID pipeline register.
- Accepts one fetched {instruction, PC+4} pair per cycle from fetch. Presents the oldest pair to decode.
- Decouples fetch from decode stalls (IF_ID_Write low) and discards all buffered instructions when the pipeline is flushed on a taken branch or jump.
- Also keeps a saturating count of discarded entries for performance debug.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- WIDTH, 32, instruction and PC+4 width in bits.
- CW, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- push_valid  input  1  fetch offers an entry this cycle.
- push_inst  input  WIDTH  fetched instruction.
- push_pc4  input  WIDTH  PC+4 of the fetched instruction.
- push_ready  output  1  queue can accept an entry (not full).
- pop_ready  input  1  decode consumes the head entry (driven from IF_ID_Write).
- pop_valid  output  1  head entry is valid.
- pop_inst  output  WIDTH  head instruction; 0 (NOP) when empty.
- pop_pc4  output  WIDTH  head PC+4; 0 when empty.
- flush  input  1  discard all entries (IF_Flush / redirect).
- count  output  CW  current occupancy, 0..DEPTH.
- flushed_cnt  output  16  saturating total of entries discarded by flush.

Behaviour:
- Reset (rst=1, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, flushed_cnt=0.
  - Resulting outputs: pop_valid=0, pop_inst=0, pop_pc4=0, push_ready=1.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards everything immediately, without waiting for a clock edge.
- Storage: circular array of DEPTH {inst, pc4} entries. wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
- Status outputs are combinational from registered state only:
  - push_ready = (count != DEPTH).
  - pop_valid = (count != 0).
  - pop_inst/pop_pc4 = mem[rd_ptr] when pop_valid, else 0.
- Push fires when push_valid & push_ready & !flush:
  - Writes mem[wr_ptr], then wr_ptr+1.
  - Push accepted while full is impossible. push_ready does not look at pop_ready, so there is no write-through when full, even if a pop happens the same cycle.
- Pop fires when pop_valid & pop_ready & !flush: rd_ptr+1.
- Latency: no bypass. An entry pushed into an empty queue is visible at pop_valid one cycle after the push edge.
- count update per edge:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- Flush (synchronous, highest priority after reset):
  - At the edge: wr_ptr=0, rd_ptr=0, count=0.
  - A push offered in the flush cycle is dropped.
  - The head shown in the flush cycle counts as discarded, not consumed, even if pop_ready=1.
  - flushed_cnt += count (pre-flush value); saturates at 16'hFFFF, never wraps.
  - Flush with count=0 leaves flushed_cnt unchanged.
- Back-to-back flushes are legal; each clears the queue.
- A push in the first cycle after flush is accepted normally.
- pop_ready while empty is ignored; pointers and count do not change.
- push_valid while full is ignored; fetch must hold (PCWrite low) until push_ready.
- Ordering: strict FIFO; entries leave in push order across pointer wrap-around.
- Memory write and pointer registers use the same clk edge. No combinational path from push_* or pop_ready to any output.

Test Plan:
1. Reset: hold rst=1 mid-stream with count=3 → same cycle count=0, pop_valid=0, pop_inst=0, push_ready=1, flushed_cnt=0.
2. Fill: push inst 0x11111111..0x44444444 (pc4 4,8,12,16) with pop_ready=0 → count=4, push_ready=0. A fifth push of 0x55555555 is ignored; popping all returns 0x11111111..0x44444444 in order.
3. Latency: single push of 0x8C220004 into empty queue → pop_valid=0 in the push cycle, 1 on the next cycle with pop_inst=0x8C220004, pop_pc4=0x00000004.
4. Simultaneous push/pop at count=2 → count stays 2 for 10 cycles. Output sequence matches input sequence across ≥3 pointer wrap-arounds.
5. Flush with count=3 plus push_valid=1 and pop_ready=1 in the same cycle → next cycle count=0, pop_valid=0, flushed_cnt=3. Dropped push is never seen.
6. Saturation: preload flushed_cnt near 16'hFFFE via repeated 4-entry flushes → after next flush flushed_cnt=16'hFFFF and stays there after further flushes.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and the IF/ID register.
// Holds {inst, pc4} pairs, drops everything on flush and counts what was dropped.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_inst,
    input  logic [WIDTH-1:0] push_pc4,
    output logic             push_ready,
    input  logic             pop_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_inst,
    output logic [WIDTH-1:0] pop_pc4,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [15:0]      flushed_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned FW = 16;

    typedef struct packed {
        logic [WIDTH-1:0] inst;
        logic [WIDTH-1:0] pc4;
    } entry_t;

    entry_t         mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [FW-1:0]  flushed_cnt_q, flushed_cnt_d;
    logic [FW:0]    flush_sum;
    logic           push_fire;
    logic           pop_fire;
    entry_t         head;

    // Status is derived purely from registered state
    assign push_ready  = (count_q != CW'(DEPTH));
    assign pop_valid   = (count_q != CW'(0));
    assign head        = mem_q[rd_ptr_q];
    assign pop_inst    = pop_valid ? head.inst : '0;
    assign pop_pc4     = pop_valid ? head.pc4  : '0;
    assign count       = count_q;
    assign flushed_cnt = flushed_cnt_q;

    assign push_fire = push_valid & push_ready & ~flush;
    assign pop_fire  = pop_valid  & pop_ready  & ~flush;

    // Flush adds the pre-flush occupancy and clamps at all-ones
    assign flush_sum = {1'b0, flushed_cnt_q} + (FW + 1)'(count_q);

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        flushed_cnt_d = flushed_cnt_q;
        if (flush) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            flushed_cnt_d = flush_sum[FW] ? {FW{1'b1}} : flush_sum[FW-1:0];
        end else begin
            if (push_fire) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_fire) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            flushed_cnt_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            flushed_cnt_q <= flushed_cnt_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_q[wr_ptr_q] <= '{inst: push_inst, pc4: push_pc4};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             push_valid;
    logic [WIDTH-1:0] push_inst;
    logic [WIDTH-1:0] push_pc4;
    logic             push_ready;
    logic             pop_ready;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_inst;
    logic [WIDTH-1:0] pop_pc4;
    logic             flush;
    logic [CW-1:0]    count;
    logic [15:0]      flushed_cnt;

    int          ncmp = 0;
    int          nfail = 0;
    logic [63:0] mq[$];
    int          mflushed = 0;

    fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_inst(push_inst), .push_pc4(push_pc4),
        .push_ready(push_ready),
        .pop_ready(pop_ready), .pop_valid(pop_valid),
        .pop_inst(pop_inst), .pop_pc4(pop_pc4),
        .flush(flush), .count(count), .flushed_cnt(flushed_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [63:0] head;
        int          sz;
        sz   = mq.size();
        head = (sz != 0) ? mq[0] : 64'd0;
        check("pop_valid",   64'(pop_valid),   64'(sz != 0));
        check("push_ready",  64'(push_ready),  64'(sz != int'(DEPTH)));
        check("pop_inst",    64'(pop_inst),    64'(head[63:32]));
        check("pop_pc4",     64'(pop_pc4),     64'(head[31:0]));
        check("count",       64'(count),       64'(sz));
        check("flushed_cnt", 64'(flushed_cnt), 64'(mflushed));
    endtask

    // One clock: drive, check pre-edge state, advance model at the edge.
    task automatic step(input logic pv, input logic [31:0] inst, input logic [31:0] pc4,
                        input logic pr, input logic fl);
        int sz;
        bit pf;
        bit qf;
        push_valid = pv;
        push_inst  = inst;
        push_pc4   = pc4;
        pop_ready  = pr;
        flush      = fl;
        check_all();
        sz = mq.size();
        pf = pv && (sz < int'(DEPTH)) && !fl;
        qf = pr && (sz != 0) && !fl;
        @(posedge clk);
        if (fl) begin
            mflushed = (mflushed + sz > 65535) ? 65535 : mflushed + sz;
            mq.delete();
        end else begin
            if (qf) void'(mq.pop_front());
            if (pf) mq.push_back({inst, pc4});
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; push_valid = 1'b0; push_inst = '0; push_pc4 = '0;
        pop_ready = 1'b0; flush = 1'b0;
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Asynchronous reset mid-stream with count=3 and a nonzero flush total
        for (int i = 0; i < 3; i++) step(1'b1, 32'hA0 + 32'(i), 32'(4 * i), 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'hB0 + 32'(i), 32'(4 * i), 1'b0, 1'b0);
        check("pre_rst_count", 64'(count), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        mq.delete();
        mflushed = 0;
        check_all();
        check("rst_count", 64'(count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill to full, extra push ignored, drain in order
        step(1'b1, 32'h11111111, 32'd4,  1'b0, 1'b0);
        step(1'b1, 32'h22222222, 32'd8,  1'b0, 1'b0);
        step(1'b1, 32'h33333333, 32'd12, 1'b0, 1'b0);
        step(1'b1, 32'h44444444, 32'd16, 1'b0, 1'b0);
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(push_ready), 64'd0);
        step(1'b1, 32'h55555555, 32'd20, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        idle();

        // Single-entry latency: not visible in the push cycle
        step(1'b1, 32'h8C220004, 32'h00000004, 1'b0, 1'b0);
        check("lat_inst", 64'(pop_inst), 64'h8C220004);
        check("lat_pc4",  64'(pop_pc4),  64'h00000004);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        idle();

        // Steady state at count=2 with concurrent push/pop across wraps
        step(1'b1, 32'hC0DE0000, 32'd100, 1'b0, 1'b0);
        step(1'b1, 32'hC0DE0001, 32'd104, 1'b0, 1'b0);
        for (int i = 2; i < 16; i++) begin
            step(1'b1, 32'hC0DE0000 + 32'(i), 32'(100 + 4 * i), 1'b1, 1'b0);
            check("steady_count", 64'(count), 64'd2);
        end
        for (int i = 0; i < 2; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Flush at count=3 with push and pop offered in the same cycle
        for (int i = 0; i < 3; i++) step(1'b1, 32'hF0 + 32'(i), 32'(8 * i), 1'b0, 1'b0);
        step(1'b1, 32'hDEADBEEF, 32'h0BAD0BAD, 1'b1, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_total", 64'(flushed_cnt), 64'd3);
        step(1'b1, 32'h12345678, 32'h0000AAA4, 1'b0, 1'b1);
        step(1'b1, 32'h9ABCDEF0, 32'h0000AAA8, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        idle();

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

        // Drive the flush total up to the saturation point with full-queue flushes
        while (mflushed + 4 <= 16'hFFFC) begin
            for (int j = 0; j < 4; j++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        end
        while (mflushed < 16'hFFFE) begin
            step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        end
        check("pre_sat", 64'(flushed_cnt), 64'hFFFE);
        for (int j = 0; j < 4; j++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("sat", 64'(flushed_cnt), 64'hFFFF);
        for (int j = 0; j < 3; j++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("sat_hold", 64'(flushed_cnt), 64'hFFFF);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
